// File: rtl/io_in_port.sv
// Input stage for the IN instruction: synchronises and debounces the switches and
// enter button, latches the switch byte per press, and serves data/status over I/O reads.
module io_in_port #(
  parameter int unsigned DB_LIMIT  = 50000,
  parameter int unsigned DB_CNT_W  = 16,
  parameter logic [7:0]  PORT_ADDR = 8'hF0,
  parameter logic [7:0]  STAT_ADDR = 8'hF1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] IN,
  input  logic       btn,
  input  logic [7:0] I_O_A,
  input  logic       rd_en,
  output logic [7:0] IO_REG_out,
  output logic       data_valid,
  output logic       overrun,
  output logic [7:0] stable_sw
);

  localparam logic [DB_CNT_W-1:0] CNT_MAX = DB_CNT_W'(DB_LIMIT - 1);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t              state, state_nxt;
  logic [7:0]          sw_s1, sw_s2, sw_cand;
  logic                btn_s1, btn_s2, btn_cand, btn_db, btn_prev;
  logic [DB_CNT_W-1:0] sw_cnt, btn_cnt;
  logic [7:0]          hold_reg, hold_nxt;
  logic                ovr_nxt;
  logic                cap, rdp, rds;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      sw_s1  <= IN;
      sw_s2  <= sw_s1;
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
    end
  end

  // Any difference from the candidate restarts the count; the counter saturates
  // so a long-stable input keeps reasserting the same debounced value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_cand   <= '0;
      sw_cnt    <= '0;
      stable_sw <= '0;
    end else if (sw_s2 != sw_cand) begin
      sw_cand <= sw_s2;
      sw_cnt  <= '0;
    end else if (sw_cnt < CNT_MAX) begin
      sw_cnt <= sw_cnt + DB_CNT_W'(1);
    end else begin
      stable_sw <= sw_cand;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_cand <= 1'b0;
      btn_cnt  <= '0;
      btn_db   <= 1'b0;
    end else if (btn_s2 != btn_cand) begin
      btn_cand <= btn_s2;
      btn_cnt  <= '0;
    end else if (btn_cnt < CNT_MAX) begin
      btn_cnt <= btn_cnt + DB_CNT_W'(1);
    end else begin
      btn_db <= btn_cand;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) btn_prev <= 1'b0;
    else     btn_prev <= btn_db;
  end

  assign cap = btn_db & ~btn_prev;
  assign rdp = rd_en && (I_O_A == PORT_ADDR);
  assign rds = rd_en && (I_O_A == STAT_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      hold_reg <= '0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_reg <= hold_nxt;
      overrun  <= ovr_nxt;
    end
  end

  // Status-read clear is applied first so a same-cycle overrun capture wins.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_reg;
    ovr_nxt   = overrun;
    if (rds) ovr_nxt = 1'b0;
    unique case (state)
      EMPTY: begin
        if (cap) begin
          hold_nxt  = stable_sw;
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (cap) begin
          hold_nxt = stable_sw;
          if (!rdp) ovr_nxt = 1'b1;
        end else if (rdp) begin
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  assign data_valid = (state == FULL);

  always_comb begin
    IO_REG_out = 8'h00;
    if (I_O_A == PORT_ADDR)      IO_REG_out = hold_reg;
    else if (I_O_A == STAT_ADDR) IO_REG_out = {6'b0, overrun, data_valid};
  end

endmodule
